// File: rtl/receiver.sv
// Audio frame receiver: holds one Ethernet frame of interleaved PCM
// and plays one sample slot (all channels) per PCM-rate strobe.
module receiver #(
  parameter int CHANNELS       = 8,
  parameter int MAX_FRAME_SIZE = 1024,
  parameter int NSAMPLES       = (MAX_FRAME_SIZE-14)/(CHANNELS*2)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_done_stb,
  input  logic [10:0]                       rx_len,
  output logic                              rx_buf_busy,
  output logic                              bram_rd_en,
  output logic [$clog2(MAX_FRAME_SIZE)-1:0] bram_rd_addr,
  input  logic [7:0]                        bram_rd_data,
  input  logic                              au_stb_pcm,
  output logic                              pcm_stb,
  output logic [$clog2(CHANNELS)-1:0]       pcm_chan,
  output logic [15:0]                       pcm_data,
  output logic [15:0]                       underrun_cnt,
  output logic [15:0]                       drop_cnt
);

  localparam int FRAME_LEN = 14 + NSAMPLES*CHANNELS*2;
  localparam int AW = $clog2(MAX_FRAME_SIZE);
  localparam int CW = $clog2(CHANNELS);
  localparam int SW = $clog2(NSAMPLES+1);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_RD_LO, S_RD_HI, S_EMIT
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_busy;
  logic           r_under;
  logic [AW-1:0]  r_ptr;
  logic [SW-1:0]  r_slot;
  logic [CW-1:0]  r_chan;
  logic [7:0]     r_lo;
  logic           r_pcm_stb;
  logic [CW-1:0]  r_pcm_chan;
  logic [15:0]    r_pcm_data;
  logic [15:0]    r_under_cnt;
  logic [15:0]    r_drop_cnt;
  logic           w_accept;
  logic           w_reject;
  logic           w_start;
  logic           w_last_ch;
  logic           w_frame_end;
  logic           w_rd_en;
  logic [AW-1:0]  w_rd_addr;

  assign w_accept = rx_done_stb && !r_busy &&
                    (rx_len == 11'(FRAME_LEN));
  assign w_reject = rx_done_stb && !w_accept;
  assign w_start  = au_stb_pcm &&
                    (r_state == S_IDLE || r_state == S_READY);
  assign w_last_ch   = (r_chan == CW'(CHANNELS-1));
  assign w_frame_end = w_last_ch && !r_under &&
                       (r_slot == SW'(NSAMPLES-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: 3 cycles per channel, back to READY/IDLE after the last
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (au_stb_pcm) w_next = S_RD_LO;
               else if (w_accept) w_next = S_READY;
      S_READY: if (au_stb_pcm) w_next = S_RD_LO;
      S_RD_LO: w_next = S_RD_HI;
      S_RD_HI: w_next = S_EMIT;
      S_EMIT: begin
        if (!w_last_ch)       w_next = S_RD_LO;
        else if (w_frame_end) w_next = S_IDLE;
        else if (!r_under)    w_next = S_READY;
        else if (r_busy || w_accept) w_next = S_READY;
        else                  w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: BRAM reads only during a real (non-underrun) burst
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = r_ptr;
    unique case (1'b1)
      (r_state == S_RD_LO): w_rd_en = !r_under;
      (r_state == S_RD_HI): begin
        w_rd_en   = !r_under;
        w_rd_addr = r_ptr + AW'(1);
      end
      default: ;
    endcase
  end

  // Frame hold flag; released one cycle after the frame's final emit
  always_ff @(posedge clk) begin
    if (rst)                   r_busy <= 1'b0;
    else if (w_accept)         r_busy <= 1'b1;
    else if (r_state == S_IDLE) r_busy <= 1'b0;
  end

  // Read pointer, slot and channel counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= AW'(14);
      r_slot  <= '0;
      r_chan  <= '0;
      r_under <= 1'b0;
    end else begin
      if (w_start) begin
        r_chan  <= '0;
        r_under <= (r_state == S_IDLE);
      end else if (r_state == S_EMIT) begin
        r_chan <= w_last_ch ? '0 : r_chan + CW'(1);
      end
      if (w_accept) begin
        r_ptr  <= AW'(14);
        r_slot <= '0;
      end else if (r_state == S_EMIT && !r_under) begin
        if (w_frame_end) begin
          r_ptr  <= AW'(14);
          r_slot <= '0;
        end else begin
          r_ptr <= r_ptr + AW'(2);
          if (w_last_ch) r_slot <= r_slot + SW'(1);
        end
      end
    end
  end

  // Sample assembly: low byte then high byte, little-endian
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo       <= '0;
      r_pcm_stb  <= 1'b0;
      r_pcm_chan <= '0;
      r_pcm_data <= '0;
    end else begin
      r_pcm_stb <= (r_state == S_EMIT);
      if (r_state == S_RD_HI) r_lo <= bram_rd_data;
      if (r_state == S_EMIT) begin
        r_pcm_chan <= r_chan;
        r_pcm_data <= r_under ? 16'h0000 : {bram_rd_data, r_lo};
      end
    end
  end

  // Saturating underrun and drop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_under_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_start && r_state == S_IDLE && r_under_cnt != 16'hFFFF)
        r_under_cnt <= r_under_cnt + 16'd1;
      if (w_reject && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign rx_buf_busy  = r_busy;
  assign bram_rd_en   = w_rd_en;
  assign bram_rd_addr = w_rd_addr;
  assign pcm_stb      = r_pcm_stb;
  assign pcm_chan     = r_pcm_chan;
  assign pcm_data     = r_pcm_data;
  assign underrun_cnt = r_under_cnt;
  assign drop_cnt     = r_drop_cnt;

endmodule
